// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the memory port arbiter. The controller and
// datapath import the same ADDR_W/DATA_W defaults, so the RAM width is set
// in one place.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester an access belongs to
//   arbitrate() : grant decision for the IDLE state
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Returns {dWin, ifWin}. A lone request always wins. On a tie the
    // requester that did not own the previous access wins, so the two
    // alternate under sustained contention.
    function automatic logic [1:0] arbitrate(input logic ifReq,
                                             input logic dReq,
                                             input owner_t lastOwner);
        logic ifWin;
        logic dWin;
        ifWin = ifReq && (!dReq || (lastOwner == OWN_D));
        dWin  = dReq  && (!ifReq || (lastOwner == OWN_IF));
        return {dWin, ifWin};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between instruction fetch (IF, read-only) and
// the data port (D, loads and stores). Accesses are serialised; the RAM read
// latency is hidden behind a req/gnt/rvalid handshake and read data is
// returned only to the requester that issued the read.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata     fetch grant, one-cycle data valid, word
//   d_req/d_we/d_addr/d_wdata     data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata        data grant, load data valid, word
//   ram_addr/ram_wdata/ram_w_en   RAM control
//   ram_rdata                     RAM read data, RD_LAT cycles after address
//   busy                          high whenever an access is in progress
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    // The read wait lasts RD_LAT cycles; the counter runs 0..RD_LAT-1 and the
    // last count is the cycle in which ram_rdata is valid.
    localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    owner_t            lastOwner_q, lastOwner_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] ifRdata_q, dRdata_q;
    logic              ifRvalid_q, dRvalid_q;
    logic              rdCapture;
    logic [1:0]        winners;

    // Next-state and grant logic. Grants exist only in IDLE and are
    // suppressed while reset is held so no handshake completes during reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastOwner_d = lastOwner_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        rdCapture   = 1'b0;
        winners     = 2'b00;

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    winners = arbitrate(if_req, d_req, lastOwner_q);
                end
                if_gnt = winners[0];
                d_gnt  = winners[1];
                if (winners[0]) begin
                    owner_d     = OWN_IF;
                    lastOwner_d = OWN_IF;
                    addr_d      = if_addr;
                    wdata_d     = '0;
                    we_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = READ_WAIT;
                end else if (winners[1]) begin
                    owner_d     = OWN_D;
                    lastOwner_d = OWN_D;
                    addr_d      = d_addr;
                    wdata_d     = d_wdata;
                    we_d        = d_we;
                    cnt_d       = '0;
                    state_d     = d_we ? WRITE : READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rdCapture = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and tie-break history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lastOwner_q <= OWN_IF;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastOwner_q <= lastOwner_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    // Read return path: the word is steered to the owner of the access and
    // held there until that owner's next read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
            ifRdata_q  <= '0;
            dRdata_q   <= '0;
        end else begin
            ifRvalid_q <= rdCapture && (owner_q == OWN_IF);
            dRvalid_q  <= rdCapture && (owner_q == OWN_D);
            if (rdCapture && (owner_q == OWN_IF)) begin
                ifRdata_q <= ram_rdata;
            end
            if (rdCapture && (owner_q == OWN_D)) begin
                dRdata_q <= ram_rdata;
            end
        end
    end

    // The RAM address is the captured address, so it holds its last value
    // in IDLE; the write strobe exists only in WRITE.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_w_en  = (state_q == WRITE) && we_q;
    assign busy      = (state_q != IDLE);
    assign if_rvalid = ifRvalid_q;
    assign d_rvalid  = dRvalid_q;
    assign if_rdata  = ifRdata_q;
    assign d_rdata   = dRdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters: instruction fetch (IF) and data load/store (D).
- The fetch and memory stages of the CPU controller issue requests here instead of driving the RAM directly.
- Serialises accesses and hides the RAM read latency behind a req/gnt/rvalid handshake.
- Returns read data to the requester that issued the read.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 32, data width
RD_LAT, 2, RAM read latency in cycles, counted from the first cycle ram_addr is driven to the cycle ram_rdata is valid; legal values 1..15

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched word
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse, d_rdata valid (loads only)
d_rdata  out  DATA_W  loaded word
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_w_en  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, last_owner = IF, counter 0, captured owner cleared. All outputs 0: gnt, rvalid, rdata, ram_*, busy.
- Reset mid-operation aborts the access. No rvalid follows, and no ram_w_en is issued after reset asserts.
- States: IDLE, READ_WAIT, WRITE.
- IDLE, cycle T. Grant is combinational from state and requests; at most one gnt per cycle.
  - Only one request asserted: grant it.
  - Both asserted: grant the one that is not last_owner (alternating). After reset D wins the first tie.
  - On grant: capture addr, wdata, we and owner into registers at the end of T, and update last_owner.
- Read grant: go to READ_WAIT.
  - ram_addr = captured addr from T+1; ram_w_en = 0.
  - Counter counts RD_LAT cycles. ram_rdata is sampled at the end of cycle T+RD_LAT.
  - The owner's rvalid is high in T+RD_LAT+1 for exactly one cycle. The owner's rdata holds that word until the owner's next read completes.
  - State returns to IDLE in T+RD_LAT+1. A new grant may occur in that same cycle.
- Write grant (D only): go to WRITE.
  - In T+1: ram_addr, ram_wdata and ram_w_en=1 are driven for exactly one cycle.
  - IDLE again in T+2. No d_rvalid for stores.
- if_req and d_we are never combined: IF is read-only.
- A requester dropping req before gnt is legal: no grant, no side effects.
- gnt is never asserted outside IDLE. Requests arriving while busy wait.
- Throughput:
  - Back-to-back reads: one per RD_LAT+1 cycles.
  - Back-to-back writes: one per 2 cycles.
- ram_addr holds its last value in IDLE. ram_w_en is 0 in every state except WRITE.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (IDLE, READ_WAIT, WRITE), owner_t enum (OWN_IF, OWN_D), ADDR_W/DATA_W defaults shared with the controller and datapath.
- No sub-module. The latency counter and tie-break are inline.

Test Plan:
- Reset: assert rst with if_req=1 -> all outputs 0, no gnt. Release rst, then if_req=1, if_addr=0x0004, RAM[4]=0xE3A01005 -> if_gnt in the first cycle, if_rvalid exactly 3 cycles later (RD_LAT=2) with if_rdata=0xE3A01005.
- Store: d_req=1, d_we=1, d_addr=0x0010, d_wdata=0xDEADBEEF -> d_gnt at T; ram_w_en=1, ram_addr=0x10, ram_wdata=0xDEADBEEF only in T+1; busy low at T+2; no d_rvalid.
- Contention: if_req and d_req (load, 0x0020) held together continuously after reset -> grants alternate D, IF, D, IF. Each rvalid goes only to its owner, with the correct word.
- Load then fetch: d_rvalid cycle coincides with if_gnt for a waiting if_req -> both occur in that cycle; the next if_rvalid follows 3 cycles later.
- Reset mid-read: rst pulsed in READ_WAIT -> no if_rvalid or d_rvalid ever appears for that access; state IDLE.
- Withdrawn request: if_req high for one cycle while in WRITE, then low -> no if_gnt, no RAM access to if_addr.
